// File: rtl/pgm_pkt_reader.sv
// rtl/pgm_pkt_reader.sv - replays a stored packet from RAM a configured number of times with PHV and gaps
module pgm_pkt_reader #(
  parameter int RAM_AW = 7,
  parameter int RAM_DW = 144
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_rd_start,
  input  logic              in_rd_stop,
  input  logic [7:0]        in_rd_pkt_lines,
  input  logic [31:0]       in_rd_repeat,
  input  logic [15:0]       in_rd_gap,
  input  logic [1023:0]     in_rd_phv,
  output logic              out_rd2ram_rd,
  output logic [RAM_AW-1:0] out_rd2ram_addr,
  input  logic [RAM_DW-1:0] in_ram2rd_rdata,
  output logic [133:0]      out_rd_data,
  output logic              out_rd_data_wr,
  output logic              out_rd_valid_wr,
  output logic              out_rd_valid,
  output logic [1023:0]     out_rd_phv,
  output logic              out_rd_phv_wr,
  input  logic              in_rd_alf,
  input  logic              in_rd_phv_alf,
  output logic              out_rd_busy,
  output logic              out_rd_done,
  output logic [31:0]       out_rd_sent_cnt
);

  localparam logic [31:0] MAX_LINES = 32'(1) << RAM_AW;

  typedef enum logic [1:0] {IDLE, CHECK, READ, GAP} state_t;

  state_t         state;
  logic [7:0]     lines_q;
  logic [31:0]    repeat_q;
  logic [15:0]    gap_q;
  logic [15:0]    gap_cnt;
  logic [1023:0]  phv_q;

  logic           start_ok;
  logic           last_line;
  logic [31:0]    sent_next;
  logic           exit_after_read;
  logic           exit_after_gap;
  logic           unused_rdata;

  assign start_ok  = in_rd_start && (in_rd_pkt_lines != 8'd0) &&
                     (32'(in_rd_pkt_lines) <= MAX_LINES);
  assign last_line = (32'(out_rd2ram_addr) + 32'd1) == 32'(lines_q);
  assign sent_next = out_rd_sent_cnt + 32'd1;

  // At the last read the packet being finished is already counted as issued.
  assign exit_after_read = in_rd_stop || ((repeat_q != 32'd0) && (sent_next == repeat_q));
  assign exit_after_gap  = in_rd_stop || ((repeat_q != 32'd0) && (out_rd_sent_cnt == repeat_q));

  // RAM data arrives one cycle after the read, aligned with the registered line strobe.
  assign out_rd_data  = out_rd_data_wr ? in_ram2rd_rdata[133:0] : 134'd0;
  assign out_rd_phv   = out_rd_phv_wr ? phv_q : 1024'd0;
  assign out_rd_valid = out_rd_valid_wr;
  assign unused_rdata = ^in_ram2rd_rdata[RAM_DW-1:134];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lines_q         <= 8'd0;
      repeat_q        <= 32'd0;
      gap_q           <= 16'd0;
      gap_cnt         <= 16'd0;
      phv_q           <= 1024'd0;
      out_rd2ram_rd   <= 1'b0;
      out_rd2ram_addr <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_valid_wr <= 1'b0;
      out_rd_busy     <= 1'b0;
      out_rd_done     <= 1'b0;
      out_rd_sent_cnt <= 32'd0;
    end else begin
      out_rd_done     <= 1'b0;
      out_rd_data_wr  <= out_rd2ram_rd;
      out_rd_phv_wr   <= out_rd2ram_rd && (out_rd2ram_addr == '0);
      out_rd_valid_wr <= out_rd2ram_rd && last_line;

      case (state)
        IDLE: begin
          if (start_ok) begin
            lines_q         <= in_rd_pkt_lines;
            repeat_q        <= in_rd_repeat;
            gap_q           <= in_rd_gap;
            phv_q           <= in_rd_phv;
            out_rd_sent_cnt <= 32'd0;
            out_rd_busy     <= 1'b1;
            state           <= CHECK;
          end
        end

        CHECK: begin
          if (in_rd_stop) begin
            out_rd_busy <= 1'b0;
            out_rd_done <= 1'b1;
            state       <= IDLE;
          end else if (!in_rd_alf && !in_rd_phv_alf) begin
            out_rd2ram_rd   <= 1'b1;
            out_rd2ram_addr <= '0;
            state           <= READ;
          end
        end

        READ: begin
          if (last_line) begin
            out_rd2ram_rd   <= 1'b0;
            out_rd2ram_addr <= '0;
            out_rd_sent_cnt <= sent_next;
            if (gap_q != 16'd0) begin
              gap_cnt <= gap_q - 16'd1;
              state   <= GAP;
            end else if (exit_after_read) begin
              out_rd_busy <= 1'b0;
              out_rd_done <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= CHECK;
            end
          end else begin
            out_rd2ram_addr <= out_rd2ram_addr + RAM_AW'(1);
          end
        end

        GAP: begin
          if (gap_cnt == 16'd0) begin
            if (exit_after_gap) begin
              out_rd_busy <= 1'b0;
              out_rd_done <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= CHECK;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pgm_pkt_reader.md
PGM_PKT_READER -- requirements
Module: pgm_pkt_reader

Interface
REQ-001 Parameter: RAM_AW, default 7, RAM address width (128 lines).
REQ-002 Parameter: RAM_DW, default 144, RAM data width; bits [133:0] carry the packet line.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_rd_start  input  1  one-cycle pulse that starts a generation run.
REQ-006 in_rd_stop  input  1  level; request to end the run at the next packet boundary.
REQ-007 in_rd_pkt_lines  input  8  lines in the stored packet, legal range 1..128; sampled on start.
REQ-008 in_rd_repeat  input  32  packets to send; 0 means continuous until stop; sampled on start.
REQ-009 in_rd_gap  input  16  idle cycles between packets; sampled on start.
REQ-010 in_rd_phv  input  1024  PHV sent with every packet; sampled on start.
REQ-011 out_rd2ram_rd  output  1  RAM read enable.
REQ-012 out_rd2ram_addr  output  7  RAM read address.
REQ-013 in_ram2rd_rdata  input  144  RAM read data, valid 1 cycle after rd.
REQ-014 out_rd_data  output  134  packet line; [133:132] 01=head, 11=middle, 10=tail.
REQ-015 out_rd_data_wr  output  1  line strobe.
REQ-016 out_rd_valid_wr / out_rd_valid  output  1 / 1  packet-end strobe / packet-good flag.
REQ-017 out_rd_phv  output  1024  PHV output.
REQ-018 out_rd_phv_wr  output  1  PHV strobe.
REQ-019 in_rd_alf / in_rd_phv_alf  input  1 / 1  downstream almost-full for data / PHV.
REQ-020 out_rd_busy  output  1  high from accepted start until return to IDLE.
REQ-021 out_rd_done  output  1  one-cycle pulse on return to IDLE.
REQ-022 out_rd_sent_cnt  output  32  packets completed in the current or last run.

Function
REQ-023 FSM states: IDLE, CHECK, READ, GAP.
REQ-024 IDLE: on in_rd_start with pkt_lines in 1..128, latch config, clear sent_cnt, set busy, go to CHECK; any other pkt_lines value ignores the start.
REQ-025 CHECK: if in_rd_stop=1, go to IDLE; else if in_rd_alf=0 and in_rd_phv_alf=0, go to READ; else stay in CHECK.
REQ-026 Backpressure is sampled only in CHECK; a packet, once in READ, streams without stall.
REQ-027 READ lasts exactly L=pkt_lines cycles, with rd=1 and addr=k in cycle k (k=0..L-1), addr starting at 0.
REQ-028 Each read produces, exactly 1 cycle later: out_rd_data_wr=1 and out_rd_data=rdata[133:0]; rdata[143:134] is discarded.
REQ-029 out_rd_phv_wr=1, with the latched PHV on out_rd_phv, in the same cycle as the first line of the packet.
REQ-030 On the last line of the packet: out_rd_valid_wr=1 and out_rd_valid=1, and sent_cnt increments by 1 in the same cycle.
REQ-031 Line-type bits are passed through unmodified; the block does not check or repair them.
REQ-032 After the last read: if gap>0, go to GAP, counting gap cycles; otherwise evaluate the exit/continue decision directly.
REQ-033 Exit/continue decision:
- If repeat≠0 and packets issued equal repeat, or in_rd_stop=1: go to IDLE, pulse done, clear busy.
- Otherwise: go to CHECK.
REQ-034 in_rd_stop and in_rd_start are ignored during READ and GAP; stop is honoured only at a boundary.
REQ-035 In continuous mode, sent_cnt wraps from 2^32-1 to 0 without side effect.
REQ-036 When not strobed, the outputs out_rd_data, out_rd_phv, out_rd_valid, out_rd2ram_addr are driven to 0.
REQ-037 Start-to-first-rd latency is 2 cycles when alf is low (IDLE→CHECK→READ); the first data_wr follows 1 cycle later.
REQ-038 Simultaneous start and stop in IDLE: the start is accepted, and CHECK then exits to IDLE with done; sent_cnt=0.

Reset
REQ-039 rst_n low forces IDLE and sets all outputs and counters to 0 immediately, including during READ; a partial packet is abandoned with no tail.
REQ-040 After reset release, no output activity occurs until a new legal start.

Verification
REQ-041 Start with lines=3, repeat=2, gap=0, RAM lines {01..,11..,10..}, alf=0 -> two 3-line packets; phv_wr on lines 1 and 4; valid_wr on lines 3 and 6; sent_cnt=2; done pulse.
REQ-042 lines=1, repeat=1 -> single line with data_wr, phv_wr and valid_wr in the same cycle; first rd 2 cycles after start.
REQ-043 lines=4, repeat=3, gap=5, in_rd_alf high 10 cycles between packets 1 and 2 -> no partial stall; packet 2 starts 1 cycle after alf falls; at least 5 idle cycles between packets.
REQ-044 repeat=0, stop raised mid-packet 7 -> packet 7 completes with tail; sent_cnt=7; done pulse; busy falls.
REQ-045 lines=128 -> addr runs 0..127 without wrap error; lines=0 or 200 -> start ignored, busy stays 0.
REQ-046 rst_n asserted in cycle 2 of READ -> all outputs 0 at once; after release, no strobes until a new start.
